// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle logic/arithmetic ops plus a bit-serial unsigned
// multiplier (shift-add) and restoring divider sharing one datapath.
module iterative_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic             is_div;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] simple_res;
  logic             slt_bit;
  logic             is_iter;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             borrow;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign is_iter   = (alu_control == OP_MULU) || (alu_control == OP_DIVU);
  assign slt_bit   = ($signed(a) < $signed(b));

  always_comb begin
    simple_res = '0;
    case (alu_control)
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR:  simple_res = ~(a | b);
      OP_NAND: simple_res = ~(a & b);
      default: simple_res = '0;
    endcase
  end

  // Multiply: hi accumulates, lo holds the multiplier and fills with product bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  // With a zero divisor the trial never borrows, which yields all-ones / a.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo[WIDTH-1:1]};
    div_shift = {hi, lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand};
    borrow    = div_trial[WIDTH];
    div_hi    = borrow ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_lo    = {lo[WIDTH-2:0], ~borrow};
    step_hi   = is_div ? div_hi : mul_hi;
    step_lo   = is_div ? div_lo : mul_lo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_div      <= 1'b0;
      mcand       <= '0;
      hi          <= '0;
      lo          <= '0;
      count       <= '0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              state  <= BUSY;
              is_div <= alu_control[0];
              mcand  <= alu_control[0] ? b : a;
              lo     <= alu_control[0] ? a : b;
              hi     <= '0;
              count  <= '0;
            end else begin
              state       <= DONE;
              result      <= simple_res;
              result_hi   <= '0;
              zero        <= (simple_res == '0);
              div_by_zero <= 1'b0;
            end
          end
        end
        BUSY: begin
          hi    <= step_hi;
          lo    <= step_lo;
          count <= count + CNT_ONE;
          if (count == LAST) begin
            state       <= DONE;
            result      <= step_lo;
            result_hi   <= step_hi;
            zero        <= (step_lo == '0);
            div_by_zero <= is_div && (mcand == '0);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Randomized and directed bench for iterative_alu (WIDTH = 16) against an
// arithmetic reference model.
module tb_iterative_alu;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_control = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         div_by_zero;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
    longint unsigned ua = av;
    longint unsigned ub = bv;
    longint unsigned p;
    longint signed   sa = $signed(av);
    longint signed   sb = $signed(bv);
    lo = '0;
    hi = '0;
    dz = 1'b0;
    case (op)
      4'b0000: lo = W'(ua & ub);
      4'b0001: lo = W'(ua | ub);
      4'b0010: lo = W'(ua + ub);
      4'b0110: lo = W'(ua - ub);
      4'b0111: lo = (sa < sb) ? W'(1) : W'(0);
      4'b1100: lo = W'(~(ua | ub));
      4'b1101: lo = W'(~(ua & ub));
      4'b1000: begin
        p  = ua * ub;
        lo = W'(p);
        hi = W'(p >> W);
      end
      4'b1001: begin
        if (ub == 0) begin
          lo = '1;
          hi = av;
          dz = 1'b1;
        end else begin
          lo = W'(ua / ub);
          hi = W'(ua % ub);
        end
      end
      default: lo = '0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int hold, input bit keep_valid);
    logic [W-1:0] el;
    logic [W-1:0] eh;
    logic         ed;
    int           lat;
    int           exp_lat;
    model(op, av, bv, el, eh, ed);
    exp_lat = (op == 4'b1000 || op == 4'b1001) ? W + 1 : 1;
    @(negedge clock);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = av; b = bv; alu_control = op;
    @(posedge clock); #1;
    if (!keep_valid) in_valid = 1'b0;
    // Scramble inputs after acceptance: the captured request must be unaffected.
    a = ~av; b = av ^ bv; alu_control = 4'b1000;
    lat = 1;
    while (!out_valid && lat < 3 * W) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clock); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    for (int i = 0; i <= hold; i++) begin
      check("out_valid", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      check("result", result, el);
      check("result_hi", result_hi, eh);
      check("zero", zero, (el == '0));
      check("div_by_zero", div_by_zero, ed);
      if (i < hold) begin
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("out_valid_clr", out_valid, 0);
    check("in_ready_ret", in_ready, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_zero", zero, 1);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
  endtask

  logic [3:0] codes [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                            4'b1100, 4'b1101, 4'b1000, 4'b1001};

  initial begin
    logic [3:0]   op;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           k;

    repeat (2) @(posedge clock);
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_result", result, 0);
    check("init_result_hi", result_hi, 0);
    check("init_zero", zero, 1);
    check("init_dbz", div_by_zero, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("init_in_ready", in_ready, 1);

    run_op(4'b0010, 16'h7FFF, 16'h0001, 0, 1'b0);
    run_op(4'b0110, 16'd5,    16'd5,    0, 1'b0);
    run_op(4'b0111, 16'hFFFF, 16'h0001, 0, 1'b0);
    run_op(4'b0111, 16'h0001, 16'hFFFF, 0, 1'b0);
    run_op(4'b1000, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(4'b1001, 16'd100,  16'd7,    0, 1'b0);
    run_op(4'b1001, 16'h1234, 16'h0000, 1, 1'b0);
    run_op(4'b0000, 16'hF0F0, 16'h3C3C, 3, 1'b1);
    run_op(4'b1100, 16'h0000, 16'h0000, 0, 1'b0);
    run_op(4'b1101, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(4'b0011, 16'h1234, 16'h5678, 0, 1'b0);

    // Abort a multiply in flight; its result must never appear.
    @(negedge clock);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; alu_control = 4'b1000;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    pulse_reset();
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clock); #1;
      check("abort_no_result", out_valid, 0);
    end
    run_op(4'b0010, 16'd2, 16'd3, 0, 1'b0);

    // Reset while a result is waiting in DONE.
    @(negedge clock);
    in_valid = 1'b1; a = 16'd9; b = 16'd4; alu_control = 4'b0010;
    @(posedge clock); #1;
    in_valid = 1'b0;
    pulse_reset();
    @(posedge clock); #1;
    check("abort_done_no_result", out_valid, 0);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 9);
      op = (k == 9) ? 4'($urandom) : codes[k];
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(op, ra, rb, $urandom_range(0, 2), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
